// File: rtl/i2c_slave_if.sv
// Register-side bundle for the I2C target: own address, enable and byte handshakes.
// gen_call exists only when GENERAL_CALL_EN is defined.
interface i2c_slave_if;
    logic       en;
    logic [6:0] address;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_load;
    logic       addr_match;
    logic       busy;
`ifdef GENERAL_CALL_EN
    logic       gen_call;

    modport slave (
        input  en, address, tx_data,
        output rx_data, rx_valid, tx_load, addr_match, busy, gen_call
    );
    modport master (
        output en, address, tx_data,
        input  rx_data, rx_valid, tx_load, addr_match, busy, gen_call
    );
`else
    modport slave (
        input  en, address, tx_data,
        output rx_data, rx_valid, tx_load, addr_match, busy
    );
    modport master (
        output en, address, tx_data,
        input  rx_data, rx_valid, tx_load, addr_match, busy
    );
`endif
endinterface

// File: rtl/i2c_slave.sv
// I2C target, 7-bit address, oversampled scl/sda, open-drain sda, no stretching.
// Define GENERAL_CALL_EN to also ACK the general-call write address.
module i2c_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl,
    inout  wire        sda,
    i2c_slave_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic scl_prev_q, sda_prev_q;
    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_ev, stop_ev;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       full_q, full_d;
    logic       rw_q, rw_d;
    logic       nack_q, nack_d;
    logic       sda_low_q, sda_low_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_load_q, tx_load_d;
    logic       addr_match_q, addr_match_d;
    logic       busy_q, busy_d;
`ifdef GENERAL_CALL_EN
    logic       gen_call_q, gen_call_d;
`endif

    assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];

    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    assign start_ev = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_ev  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        full_d       = full_q;
        rw_d         = rw_q;
        nack_d       = nack_q;
        sda_low_d    = sda_low_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        tx_load_d    = 1'b0;
        addr_match_d = addr_match_q;
        busy_d       = busy_q;
`ifdef GENERAL_CALL_EN
        gen_call_d   = gen_call_q;
`endif
        if (!bus.en || stop_ev) begin
            state_d      = IDLE;
            cnt_d        = 3'd0;
            full_d       = 1'b0;
            sda_low_d    = 1'b0;
            addr_match_d = 1'b0;
            busy_d       = 1'b0;
`ifdef GENERAL_CALL_EN
            gen_call_d   = 1'b0;
`endif
        end else if (start_ev) begin
            state_d      = ADDR;
            cnt_d        = 3'd0;
            full_d       = 1'b0;
            sda_low_d    = 1'b0;
            addr_match_d = 1'b0;
            busy_d       = 1'b1;
`ifdef GENERAL_CALL_EN
            gen_call_d   = 1'b0;
`endif
        end else begin
            unique case (state_q)
                ADDR, RX_DATA: begin
                    // full_q marks "8 bits in, waiting for the ACK-slot fall"
                    if (scl_rise && !full_q) begin
                        shift_d = {shift_q[6:0], sda_s};
                        if (cnt_q == 3'd7) begin
                            full_d = 1'b1;
                            if (state_q == RX_DATA) begin
                                rx_data_d  = {shift_q[6:0], sda_s};
                                rx_valid_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else if (scl_fall && full_q) begin
                        full_d = 1'b0;
                        cnt_d  = 3'd0;
                        if (state_q == RX_DATA) begin
                            state_d   = RX_ACK;
                            sda_low_d = 1'b1;
                        end else if (shift_q[7:1] == bus.address) begin
                            state_d      = ADDR_ACK;
                            sda_low_d    = 1'b1;
                            rw_d         = shift_q[0];
                            addr_match_d = 1'b1;
`ifdef GENERAL_CALL_EN
                        end else if (shift_q == 8'h00) begin
                            state_d    = ADDR_ACK;
                            sda_low_d  = 1'b1;
                            rw_d       = 1'b0;
                            gen_call_d = 1'b1;
`endif
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = 3'd0;
                        if (rw_q) begin
                            state_d   = TX_DATA;
                            shift_d   = bus.tx_data;
                            sda_low_d = ~bus.tx_data[7];
                            tx_load_d = 1'b1;
                        end else begin
                            state_d   = RX_DATA;
                            sda_low_d = 1'b0;
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        state_d   = RX_DATA;
                        sda_low_d = 1'b0;
                        cnt_d     = 3'd0;
                    end
                end
                TX_DATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd7) begin
                            state_d   = TX_ACK;
                            sda_low_d = 1'b0;
                            cnt_d     = 3'd0;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_low_d = ~shift_q[6];
                            cnt_d     = cnt_q + 3'd1;
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise && !full_q) begin
                        nack_d = sda_s;
                        full_d = 1'b1;
                    end else if (scl_fall && full_q) begin
                        full_d = 1'b0;
                        cnt_d  = 3'd0;
                        if (nack_q) begin
                            state_d = IGNORE;
                        end else begin
                            state_d   = TX_DATA;
                            shift_d   = bus.tx_data;
                            sda_low_d = ~bus.tx_data[7];
                            tx_load_d = 1'b1;
                        end
                    end
                end
                default: begin
                    sda_low_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q   <= '1;
            sda_sync_q   <= '1;
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            shift_q      <= 8'h00;
            full_q       <= 1'b0;
            rw_q         <= 1'b0;
            nack_q       <= 1'b0;
            sda_low_q    <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            tx_load_q    <= 1'b0;
            addr_match_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef GENERAL_CALL_EN
            gen_call_q   <= 1'b0;
`endif
        end else begin
            scl_sync_q   <= scl_sync_d;
            sda_sync_q   <= sda_sync_d;
            scl_prev_q   <= scl_s;
            sda_prev_q   <= sda_s;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            full_q       <= full_d;
            rw_q         <= rw_d;
            nack_q       <= nack_d;
            sda_low_q    <= sda_low_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            tx_load_q    <= tx_load_d;
            addr_match_q <= addr_match_d;
            busy_q       <= busy_d;
`ifdef GENERAL_CALL_EN
            gen_call_q   <= gen_call_d;
`endif
        end
    end

    assign sda            = sda_low_q ? 1'b0 : 1'bz;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.tx_load    = tx_load_q;
    assign bus.addr_match = addr_match_q;
    assign bus.busy       = busy_q;
`ifdef GENERAL_CALL_EN
    assign bus.gen_call   = gen_call_q;
`endif

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, directed cases, then random
// transactions scored against a byte-level model of the target.
module tb_i2c_slave;

    localparam int Q = 40;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic scl = 1'b1;
    logic m_low = 1'b0;
    wire  sda_bus;

    assign sda_bus = m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_slave_if bus_if ();

    i2c_slave #(.SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .scl     (scl),
        .sda     (sda_bus),
        .bus     (bus_if.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int rxv_cnt = 0;
    int txl_cnt = 0;
    int slave_low_cnt = 0;
    int busy_drop = 0;
    int drive_viol = 0;
    logic in_xfer = 1'b0;
    logic [7:0] rx_last = 8'h00;
    logic scl_prev = 1'b1;
    logic m_low_prev = 1'b0;
    logic sda_prev = 1'b1;

    always @(negedge clk) begin
        if (bus_if.rx_valid) begin
            rxv_cnt++;
            rx_last = bus_if.rx_data;
        end
        if (bus_if.tx_load) txl_cnt++;
        if (!m_low && sda_bus === 1'b0) slave_low_cnt++;
        if (in_xfer && !bus_if.busy) busy_drop++;
        if (scl && scl_prev && m_low == m_low_prev && sda_bus !== sda_prev)
            drive_viol++;
        scl_prev   = scl;
        m_low_prev = m_low;
        sda_prev   = sda_bus;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic i2c_start;
        m_low = 1'b1; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic i2c_stop;
        m_low = 1'b1; #Q;
        scl = 1'b1;   #Q;
        m_low = 1'b0; #(2*Q);
    endtask

    task automatic i2c_rstart;
        m_low = 1'b0; #Q;
        scl = 1'b1;   #Q;
        m_low = 1'b1; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic wbit(input logic b);
        m_low = ~b; #Q;
        scl = 1'b1; #(2*Q);
        scl = 1'b0; #Q;
    endtask

    task automatic rbit(output logic b);
        m_low = 1'b0; #Q;
        scl = 1'b1;   #Q;
        b = sda_bus;  #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(ack);
    endtask

    task automatic rbyte(output logic [7:0] d, input logic ack,
                         input logic [7:0] nxt);
        logic b;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
            if (i == 4) bus_if.tx_data = 8'($urandom);
        end
        bus_if.tx_data = nxt;
        wbit(ack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d, exp, nxt, rx_before;
        logic [6:0] own, tgt;
        logic       rw, match;
        int         n, rxv0, txl0, low0;

        bus_if.en      = 1'b1;
        bus_if.address = 7'h70;
        bus_if.tx_data = 8'h00;
        #23;
        chk("rst_rx_data", bus_if.rx_data, 8'h00);
        chk("rst_rx_valid", bus_if.rx_valid, 1'b0);
        chk("rst_tx_load", bus_if.tx_load, 1'b0);
        chk("rst_addr_match", bus_if.addr_match, 1'b0);
        chk("rst_busy", bus_if.busy, 1'b0);
        chk("rst_sda", sda_bus, 1'b1);
        reset_n = 1'b1;
        #100;

        // write 0xA5 to 0x70
        rxv0 = rxv_cnt;
        i2c_start();
        chk("wr_busy", bus_if.busy, 1'b1);
        wbyte(8'hE0, ack);
        chk("wr_addr_ack", ack, 1'b0);
        chk("wr_addr_match", bus_if.addr_match, 1'b1);
        wbyte(8'hA5, ack);
        chk("wr_data_ack", ack, 1'b0);
        chk("wr_rx_data", bus_if.rx_data, 8'hA5);
        chk("wr_rx_valid_n", rxv_cnt - rxv0, 1);
        i2c_stop();
        chk("wr_busy_stop", bus_if.busy, 1'b0);
        chk("wr_match_stop", bus_if.addr_match, 1'b0);

        // read two bytes, ACK then NACK
        txl0 = txl_cnt;
        bus_if.tx_data = 8'h0F;
        i2c_start();
        wbyte(8'hE1, ack);
        chk("rd_addr_ack", ack, 1'b0);
        rbyte(d, 1'b0, 8'h0F);
        chk("rd_byte0", d, 8'h0F);
        rbyte(d, 1'b1, 8'hFF);
        chk("rd_byte1", d, 8'h0F);
        chk("rd_tx_load_n", txl_cnt - txl0, 2);
        #(2*Q);
        chk("rd_release", sda_bus, 1'b1);
        i2c_stop();

        // mismatched address
        rxv0 = rxv_cnt;
        low0 = slave_low_cnt;
        i2c_start();
        wbyte({7'h55, 1'b0}, ack);
        chk("mis_addr_nack", ack, 1'b1);
        wbyte(8'h12, ack);
        chk("mis_data_nack", ack, 1'b1);
        chk("mis_addr_match", bus_if.addr_match, 1'b0);
        i2c_stop();
        chk("mis_no_drive", slave_low_cnt - low0, 0);
        chk("mis_no_rx", rxv_cnt - rxv0, 0);

        // abort after 4 data bits
        rxv0 = rxv_cnt;
        rx_before = bus_if.rx_data;
        i2c_start();
        wbyte(8'hE0, ack);
        for (int i = 0; i < 4; i++) wbit(1'b0);
        i2c_stop();
        chk("abort_no_rx", rxv_cnt - rxv0, 0);
        chk("abort_rx_data", bus_if.rx_data, rx_before);
        chk("abort_busy", bus_if.busy, 1'b0);

        // write 0x3C, repeated START, read
        rxv0 = rxv_cnt;
        busy_drop = 0;
        i2c_start();
        in_xfer = 1'b1;
        wbyte(8'hE0, ack);
        wbyte(8'h3C, ack);
        chk("rs_wr_ack", ack, 1'b0);
        i2c_rstart();
        chk("rs_rx_data", bus_if.rx_data, 8'h3C);
        bus_if.tx_data = 8'h96;
        wbyte(8'hE1, ack);
        chk("rs_rd_addr_ack", ack, 1'b0);
        rbyte(d, 1'b1, 8'h00);
        chk("rs_rd_byte", d, 8'h96);
        in_xfer = 1'b0;
        chk("rs_busy_held", busy_drop, 0);
        chk("rs_rx_n", rxv_cnt - rxv0, 1);
        i2c_stop();

        // reset while the address ACK is held
        i2c_start();
        for (int i = 7; i >= 0; i--) wbit(i == 7 || i == 6 || i == 5);
        m_low = 1'b0;
        #5;
        chk("ack_held", sda_bus, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("rst_ack_release", sda_bus, 1'b1);
        chk("rst_ack_match", bus_if.addr_match, 1'b0);
        chk("rst_ack_busy", bus_if.busy, 1'b0);
        chk("rst_ack_rx_data", bus_if.rx_data, 8'h00);
        #4;
        scl = 1'b1;
        #Q;
        reset_n = 1'b1;
        #100;

        // random transactions
        for (int it = 0; it < 16; it++) begin
            own = 7'($urandom_range(1, 127));
            bus_if.address = own;
            tgt = ($urandom_range(0, 1) == 1) ? own : 7'($urandom);
            rw = 1'($urandom);
            n = $urandom_range(1, 3);
            match = (tgt == own);
`ifdef GENERAL_CALL_EN
            if (tgt == 7'd0 && !rw) match = 1'b1;
`endif
            rxv0 = rxv_cnt;
            txl0 = txl_cnt;
            exp = 8'($urandom);
            bus_if.tx_data = exp;
            i2c_start();
            wbyte({tgt, rw}, ack);
            chk("rnd_addr_ack", ack, !match);
            chk("rnd_addr_match", bus_if.addr_match, tgt == own);
            if (!rw) begin
                for (int k = 0; k < n; k++) begin
                    d = 8'($urandom);
                    wbyte(d, ack);
                    chk("rnd_wr_ack", ack, !match);
                    if (match) exp = d;
                end
                chk("rnd_rx_n", rxv_cnt - rxv0, match ? n : 0);
                if (match) chk("rnd_rx_last", rx_last, exp);
            end else begin
                for (int k = 0; k < n; k++) begin
                    nxt = 8'($urandom);
                    rbyte(d, k == n - 1, nxt);
                    chk("rnd_rd_byte", d, match ? exp : 8'hFF);
                    exp = nxt;
                end
                chk("rnd_tx_load_n", txl_cnt - txl0, match ? n : 0);
            end
            i2c_stop();
            chk("rnd_busy_stop", bus_if.busy, 1'b0);
        end

        chk("sda_stable_scl_high", drive_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C responder (target) for the on-chip two-wire bus. It answers a 7-bit address, accepts write bytes and returns read bytes.
- Runs on a local system clock and oversamples the bus. `scl` is input-only: no clock stretching.
- Open-drain on `sda`: it only ever pulls low or releases.
- Sits opposite the bus master on the shared `sda`/`scl` pair. It hands received bytes to, and fetches transmit bytes from, the register/tag logic.

Parameters:
- SYNC_STAGES, 2, flops in each `scl`/`sda` input synchronizer (minimum 2).

Ports:
- clk  input  1  system clock; must run at ≥8x the `scl` frequency
- reset_n  input  1  asynchronous active-low reset
- en  input  1  block enable; low forces IDLE and releases `sda`
- address  input  7  own slave address
- tx_data  input  8  byte returned on read; sampled at load points
- sda  inout  1  open-drain data: driven 0 or z
- scl  input  1  bus clock from the master
- rx_data  output  8  last received write byte
- rx_valid  output  1  one-clk pulse when `rx_data` updates
- tx_load  output  1  one-clk pulse when `tx_data` is sampled
- addr_match  output  1  high from address ACK until STOP/repeated START
- busy  output  1  high between START and STOP

Behaviour:
- Reset values (async, `reset_n` low):
  - state = IDLE, `sda` released (z).
  - `rx_data` = 0; `rx_valid`, `tx_load`, `addr_match`, `busy` = 0.
  - Bit counter = 0, shift register = 0.
- Input conditioning:
  - `scl` and `sda` pass through SYNC_STAGES flops, then one history flop for edge detect.
  - Events are seen SYNC_STAGES+1 clk cycles after the pin change.
- Bus events:
  - START: `sda` falls while `scl` high.
  - STOP: `sda` rises while `scl` high.
  - Data is sampled on `scl` rise. The slave changes its `sda` drive only on `scl` fall.
- Event priority, highest first:
  1. reset
  2. `en` low → IDLE
  3. STOP → IDLE, `busy` 0, `addr_match` 0
  4. START, including repeated START from any state → ADDR, counter 0, `busy` 1, `addr_match` 0
  5. normal bit processing
- States:
  - IDLE: `sda` released; wait for START.
  - ADDR:
    - Shift 7 address bits plus the R/W bit, MSB first.
    - After the 8th rise, on the next `scl` fall: if the address equals `address`, go to ADDR_ACK and drive `sda` 0. Otherwise go to IGNORE.
  - ADDR_ACK:
    - Hold `sda` low through the ACK clock. Set `addr_match` 1.
    - On the ACK `scl` fall, write (R/W=0): release `sda`, go to RX_DATA.
    - On the ACK `scl` fall, read (R/W=1): pulse `tx_load`, latch `tx_data`, drive bit 7 (0 → drive low, 1 → release), go to TX_DATA.
  - RX_DATA:
    - Shift 8 bits on `scl` rise.
    - On the 8th rise: `rx_data` ← shifted byte, `rx_valid` pulses in the following clk.
    - On the next fall: drive `sda` 0, go to RX_ACK.
  - RX_ACK: on `scl` fall, release `sda`, counter 0, go to RX_DATA.
  - TX_DATA:
    - On each `scl` fall, present the next bit, MSB first.
    - After the 8th bit's fall: release `sda`, go to TX_ACK.
  - TX_ACK:
    - Sample the master's ACK on `scl` rise.
    - ACK (0): on the next fall, pulse `tx_load`, latch a new byte, drive bit 7, go to TX_DATA.
    - NACK (1): go to IGNORE.
  - IGNORE: `sda` released; wait for STOP or START.
- Boundaries:
  - STOP or START mid-byte aborts the byte: no `rx_valid`, partial data discarded.
  - `tx_data` changing outside a `tx_load` cycle has no effect.
  - Reset mid-ACK releases `sda` immediately (asynchronous).
  - The counter wraps 7→0 only via an ACK state; it never exceeds 7.
  - `sda` is never driven while `scl` is high, except holding an ACK or data bit already set up.

Optional Feature:
- GENERAL_CALL_EN
  - Defined: address 7'b0000000 with R/W=0 is also ACKed and handled as a write.
  - `addr_match` stays 0 for a general call. An extra output `gen_call` is high from the address ACK until STOP/START.
  - Undefined: address 0 matches only if `address` == 0. `gen_call` is absent.

Test Plan:
1. Write, match: `address`=7'b1110000; master sends START, 0xE0, 0xA5, STOP → slave ACKs both bytes; `rx_data`=0xA5 with one `rx_valid` pulse; `busy` falls after STOP.
2. Read: `tx_data`=0x0F; master sends START, 0xE1, reads 2 bytes (ACK then NACK) → bus carries 0x0F, 0x0F; `tx_load` pulses twice; slave releases `sda` after the NACK.
3. Mismatch: master addresses 7'b1010101 → `sda` never driven low by the slave; `addr_match` stays 0; `rx_valid` never pulses.
4. Abort: STOP after 4 data bits of a write → no `rx_valid`; state IDLE; `rx_data` unchanged.
5. Repeated START: write 0x3C, repeated START, read → `rx_data`=0x3C, then read data driven correctly; `busy` stays 1 throughout.
6. Reset during address ACK → `sda` released within the same clk; all outputs at reset values.
